// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional misaligned-PC checking is enabled with FETCH_ALIGN_CHK_EN.
package fetch_pkg;
    localparam int XLEN = 16;
    typedef logic [XLEN-1:0] word_t;

    localparam word_t      DEF_RESET_PC  = 16'h0000;
    localparam word_t      DEF_NOP_INSTR = 16'h0800;
    localparam logic [4:0] DEF_HALT_OPC  = 5'b00000;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    function automatic logic [4:0] opcode_of(input word_t instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
    import fetch_pkg::*;

    word_t imem_addr;
    logic  imem_en;
    logic  imem_wr;
    word_t imem_data;

    modport master (
        output imem_addr,
        output imem_en,
        output imem_wr,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        input  imem_wr,
        output imem_data
    );
endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: flush loads a NOP bubble, hold freezes the contents.
module fetch_ifid_reg
    import fetch_pkg::*;
#(
    parameter word_t NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  flush,
    input  word_t load_instr,
    input  word_t load_pc2,
    output word_t instr,
    output word_t pc2,
    output logic  valid
);
    word_t instr_reg;
    word_t pc2_reg;
    logic  valid_reg;

    // Flush beats hold so a redirect during a stall still kills the bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_reg <= NOP_INSTR;
            pc2_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (flush) begin
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (!hold) begin
            instr_reg <= load_instr;
            pc2_reg   <= load_pc2;
            valid_reg <= 1'b1;
        end
    end

    assign instr = instr_reg;
    assign pc2   = pc2_reg;
    assign valid = valid_reg;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handles stall/redirect/HALT and feeds IF/ID.
// Define FETCH_ALIGN_CHK_EN to trap fetches from odd PCs via the sticky err flag.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter word_t      RESET_PC  = DEF_RESET_PC,
    parameter word_t      NOP_INSTR = DEF_NOP_INSTR,
    parameter logic [4:0] HALT_OPC  = DEF_HALT_OPC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  word_t                redirect_pc,
    fetch_stage_if.master        imem,
    output word_t                ifid_instr,
    output word_t                ifid_pc2,
    output logic                 ifid_valid,
    output logic                 halted,
    output logic                 err
);
    fetch_state_e state_reg, state_next;
    word_t        pc_reg, pc_next;
    word_t        pc_plus2;
    logic         ifid_hold;
    logic         ifid_flush;
    logic         fetch_go;
    logic         misaligned;

    assign pc_plus2 = pc_reg + 16'd2;
    assign fetch_go = !redirect_valid && !stall && (state_reg == ST_RUN);

`ifdef FETCH_ALIGN_CHK_EN
    assign misaligned = pc_reg[0];
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        if (redirect_valid) begin
            pc_next    = redirect_pc;
            ifid_flush = 1'b1;
            state_next = ST_RUN;
        end else if (stall) begin
            ifid_hold = 1'b1;
        end else if (state_reg == ST_HALTED) begin
            ifid_flush = 1'b1;
        end else if (misaligned) begin
            ifid_flush = 1'b1;
            state_next = ST_HALTED;
        end else if (opcode_of(imem.imem_data) == HALT_OPC) begin
            // HALT itself is passed to decode; the PC parks on its address.
            state_next = ST_HALTED;
        end else begin
            pc_next = pc_plus2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RUN;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    logic err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (fetch_go && misaligned) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    fetch_ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .hold       (ifid_hold),
        .flush      (ifid_flush),
        .load_instr (imem.imem_data),
        .load_pc2   (pc_plus2),
        .instr      (ifid_instr),
        .pc2        (ifid_pc2),
        .valid      (ifid_valid)
    );

    // Memory loads its image during reset, so the read enable is gated by rst directly.
    assign imem.imem_addr = pc_reg;
    assign imem.imem_en   = ~rst & (state_reg == ST_RUN);
    assign imem.imem_wr   = 1'b0;
    assign halted         = (state_reg == ST_HALTED);
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle reference model plus literal spot checks.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc2;
    logic        ifid_valid;
    logic        halted;
    logic        err;

    logic [15:0] halt_addr = 16'h0001;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_pc    = 16'h0000;
    logic        m_run   = 1'b1;
    logic [15:0] m_instr = 16'h0800;
    logic [15:0] m_pc2   = 16'h0000;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;

    fetch_stage_if imem_bus ();

    always #5 clk = ~clk;

    // Memory image: every word is a non-HALT opcode except at halt_addr.
    assign imem_bus.imem_data = (imem_bus.imem_addr == halt_addr) ? 16'h0000
                              : (16'h8000 | {1'b0, imem_bus.imem_addr[15:1]});

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus.master),
        .ifid_instr     (ifid_instr),
        .ifid_pc2       (ifid_pc2),
        .ifid_valid     (ifid_valid),
        .halted         (halted),
        .err            (err)
    );

    function automatic logic [15:0] word_at(input logic [15:0] a);
        if (a == halt_addr) return 16'h0000;
        return 16'h8000 | {1'b0, a[15:1]};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_update();
        logic [15:0] w;
        if (rst) begin
            m_pc = 16'h0000; m_run = 1'b1; m_instr = 16'h0800;
            m_pc2 = 16'h0000; m_valid = 1'b0; m_err = 1'b0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_run = 1'b1; m_instr = 16'h0800; m_valid = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (!m_run) begin
            m_instr = 16'h0800; m_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        end else if (m_pc[0]) begin
            m_err = 1'b1; m_run = 1'b0; m_instr = 16'h0800; m_valid = 1'b0;
`endif
        end else begin
            w = word_at(m_pc);
            m_instr = w;
            m_pc2 = m_pc + 16'd2;
            m_valid = 1'b1;
            if (w[15:11] == 5'b00000) m_run = 1'b0;
            else m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic compare();
        chk("imem_addr", imem_bus.imem_addr, m_pc);
        chk("imem_en", {15'd0, imem_bus.imem_en}, {15'd0, ~rst & m_run});
        chk("imem_wr", {15'd0, imem_bus.imem_wr}, 16'd0);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
        if (m_valid || rst) chk("ifid_pc2", ifid_pc2, m_pc2);
        chk("halted", {15'd0, halted}, {15'd0, ~m_run});
        chk("err", {15'd0, err}, {15'd0, m_err});
        $display("t=%0t rst=%b stall=%b rv=%b rpc=%h | addr=%h en=%b instr=%h pc2=%h v=%b halted=%b err=%b",
                 $time, rst, stall, redirect_valid, redirect_pc, imem_bus.imem_addr,
                 imem_bus.imem_en, ifid_instr, ifid_pc2, ifid_valid, halted, err);
    endtask

    task automatic step(input logic r, input logic s, input logic rv, input logic [15:0] rp);
        @(negedge clk);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 16'h0000);
        step(1, 0, 0, 16'h0000);
        chk("rst_instr_lit", ifid_instr, 16'h0800);
        chk("rst_en_lit", {15'd0, imem_bus.imem_en}, 16'd0);

        // Sequential fetch from 0,2 then stall at PC=4
        step(0, 0, 0, 16'h0000);
        chk("seq0_instr_lit", ifid_instr, 16'h8000);
        chk("seq0_pc2_lit", ifid_pc2, 16'h0002);
        step(0, 0, 0, 16'h0000);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0000);
        chk("stall_addr_lit", imem_bus.imem_addr, 16'h0004);
        chk("stall_pc2_lit", ifid_pc2, 16'h0004);
        halt_addr = 16'h0008;
        step(0, 0, 0, 16'h0000);
        step(0, 0, 0, 16'h0000);
        chk("seq3_instr_lit", ifid_instr, 16'h8003);
        chk("seq3_pc2_lit", ifid_pc2, 16'h0008);

        // HALT at address 8
        step(0, 0, 0, 16'h0000);
        chk("halt_instr_lit", ifid_instr, 16'h0000);
        chk("halt_flag_lit", {15'd0, halted}, 16'd1);
        chk("halt_pc_lit", imem_bus.imem_addr, 16'h0008);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 1, 16'h0010);
        chk("resume_halted_lit", {15'd0, halted}, 16'd0);
        step(0, 0, 0, 16'h0000);
        chk("resume_instr_lit", ifid_instr, 16'h8008);

        // Redirect while stalled
        step(0, 1, 1, 16'h0040);
        chk("redir_addr_lit", imem_bus.imem_addr, 16'h0040);
        chk("redir_valid_lit", {15'd0, ifid_valid}, 16'd0);
        step(0, 0, 0, 16'h0000);
        chk("redir_pc2_lit", ifid_pc2, 16'h0042);

        // PC wrap at 0xFFFE
        step(0, 0, 1, 16'hFFFE);
        step(0, 0, 0, 16'h0000);
        chk("wrap_pc2_lit", ifid_pc2, 16'h0000);
        chk("wrap_addr_lit", imem_bus.imem_addr, 16'h0000);

        // HALT presented under stall is not accepted until release
        step(0, 0, 1, 16'h0008);
        step(0, 1, 0, 16'h0000);
        step(0, 1, 0, 16'h0000);
        chk("stall_halt_lit", {15'd0, halted}, 16'd0);
        step(0, 0, 0, 16'h0000);
        chk("unstall_halt_lit", {15'd0, halted}, 16'd1);

        // Reset from HALTED
        step(1, 0, 0, 16'h0000);
        chk("rst_from_halt_lit", {15'd0, halted}, 16'd0);
        step(0, 0, 0, 16'h0000);

        // Odd PC
        step(0, 0, 1, 16'h0021);
        step(0, 0, 0, 16'h0000);
`ifdef FETCH_ALIGN_CHK_EN
        chk("align_err_lit", {15'd0, err}, 16'd1);
        chk("align_halted_lit", {15'd0, halted}, 16'd1);
`else
        chk("odd_pc2_lit", ifid_pc2, 16'h0023);
        chk("odd_err_lit", {15'd0, err}, 16'd0);
`endif
        step(0, 0, 0, 16'h0000);
        step(1, 0, 0, 16'h0000);
        chk("final_err_lit", {15'd0, err}, 16'd0);
        chk("final_pc_lit", imem_bus.imem_addr, 16'h0000);
        step(0, 0, 0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
